// File: rtl/rv_csr_rmw_if.sv
// Request/response and trap/export bundle between CSR decode, counter mux,
// fetch/interrupt logic and the rv_csr_rmw engine.
interface rv_csr_rmw_if;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [11:0] i_idx;
  logic [1:0]  i_op;
  logic        i_sel;
  logic [4:0]  i_imm;
  logic [31:0] i_data;
  logic [31:0] i_ext_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_rdata;
  logic        o_illegal;
  logic        i_trap;
  logic [31:0] i_trap_cause;
  logic [31:0] i_trap_pc;
  logic [31:0] i_trap_val;
  logic        i_mret;
  logic [31:0] o_mtvec;
  logic [31:0] o_mepc;
  logic        o_mie_global;

  modport master (
    output i_flush, i_valid, i_idx, i_op, i_sel, i_imm, i_data, i_ext_rdata,
           i_ready, i_trap, i_trap_cause, i_trap_pc, i_trap_val, i_mret,
    input  o_ready, o_valid, o_rdata, o_illegal, o_mtvec, o_mepc, o_mie_global
  );

  modport slave (
    input  i_flush, i_valid, i_idx, i_op, i_sel, i_imm, i_data, i_ext_rdata,
           i_ready, i_trap, i_trap_cause, i_trap_pc, i_trap_val, i_mret,
    output o_ready, o_valid, o_rdata, o_illegal, o_mtvec, o_mepc, o_mie_global
  );
endinterface

// File: rtl/rv_csr_rmw.sv
// Machine-mode CSR storage with a four-step read-modify-write sequencer,
// plus trap-entry and mret side effects on mstatus/mepc/mcause/mtval.
//
// state | meaning
// IDLE  | ready; latch request on i_valid
// READ  | capture old value, classify legality
// EXEC  | compute and commit new value, load response
// RESP  | hold response until i_ready
module rv_csr_rmw #(
  parameter logic [31:0] MISA_VALUE  = 32'h40000100,
  parameter logic [31:0] MTVEC_RESET = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  rv_csr_rmw_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_RESP} state_t;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;

  localparam logic [31:0] MIE_MASK = 32'h00000888;

  state_t state, state_nxt;

  logic [11:0] idx_q;
  logic [1:0]  op_q;
  logic        sel_q;
  logic [4:0]  imm_q;
  logic [31:0] data_q;
  logic [31:0] old_q;
  logic        illegal_q;
  logic [31:0] rdata_q;
  logic        illegal_out_q;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic        abort;
  logic        local_hit, ext_hit, wr_en, illegal_rd, commit;
  logic [31:0] local_rdata, src, new_val;

  // A trap behaves as a flush of whatever is in flight.
  assign abort = bus.i_flush | bus.i_trap;

  always_comb begin
    local_hit   = 1'b1;
    local_rdata = 32'h0;
    case (idx_q)
      A_MSTATUS:  local_rdata = {24'h0, mst_mpie, 3'b000, mst_mie, 3'b000};
      A_MISA:     local_rdata = MISA_VALUE;
      A_MIE:      local_rdata = mie_q;
      A_MTVEC:    local_rdata = mtvec_q;
      A_MSCRATCH: local_rdata = mscratch_q;
      A_MEPC:     local_rdata = mepc_q;
      A_MCAUSE:   local_rdata = mcause_q;
      A_MTVAL:    local_rdata = mtval_q;
      A_MIP:      local_rdata = 32'h0;
      default:    local_hit   = 1'b0;
    endcase
  end

  assign ext_hit    = (idx_q[11:8] == 4'hB) || (idx_q[11:8] == 4'hC);
  assign wr_en      = (op_q == OP_RW) || (((op_q == OP_RS) || (op_q == OP_RC)) && (imm_q != 5'd0));
  assign illegal_rd = !(local_hit || ext_hit) || ((idx_q[11:10] == 2'b11) && wr_en);
  assign src        = sel_q ? {27'h0, imm_q} : data_q;

  always_comb begin
    new_val = src;
    case (op_q)
      OP_RS:   new_val = old_q | src;
      OP_RC:   new_val = old_q & ~src;
      default: new_val = src;
    endcase
  end

  assign commit = (state == S_EXEC) && !abort && wr_en && !illegal_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.i_valid && !abort) state_nxt = S_READ;
      S_READ: state_nxt = abort ? S_IDLE : S_EXEC;
      S_EXEC: state_nxt = abort ? S_IDLE : S_RESP;
      S_RESP: if (abort || bus.i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx_q         <= 12'h0;
      op_q          <= 2'b00;
      sel_q         <= 1'b0;
      imm_q         <= 5'd0;
      data_q        <= 32'h0;
      old_q         <= 32'h0;
      illegal_q     <= 1'b0;
      rdata_q       <= 32'h0;
      illegal_out_q <= 1'b0;
      mst_mie       <= 1'b0;
      mst_mpie      <= 1'b0;
      mie_q         <= 32'h0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= 32'h0;
      mepc_q        <= 32'h0;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
    end else begin
      if ((state == S_IDLE) && bus.i_valid && !abort) begin
        idx_q  <= bus.i_idx;
        op_q   <= bus.i_op;
        sel_q  <= bus.i_sel;
        imm_q  <= bus.i_imm;
        data_q <= bus.i_data;
      end
      if (state == S_READ) begin
        old_q     <= ext_hit ? bus.i_ext_rdata : local_rdata;
        illegal_q <= illegal_rd;
      end
      if ((state == S_EXEC) && !abort) begin
        rdata_q       <= illegal_q ? 32'h0 : old_q;
        illegal_out_q <= illegal_q;
      end
      // misa, mip and counter writes fall through to default and are dropped.
      if (commit) begin
        case (idx_q)
          A_MSTATUS: if (!bus.i_mret) begin
            mst_mie  <= new_val[3];
            mst_mpie <= new_val[7];
          end
          A_MIE:      mie_q      <= new_val & MIE_MASK;
          A_MTVEC:    mtvec_q    <= {new_val[31:2], 2'b00};
          A_MSCRATCH: mscratch_q <= new_val;
          A_MEPC:     mepc_q     <= {new_val[31:2], 2'b00};
          A_MCAUSE:   mcause_q   <= new_val;
          A_MTVAL:    mtval_q    <= new_val;
          default: ;
        endcase
      end
      if (bus.i_trap) begin
        mepc_q   <= {bus.i_trap_pc[31:2], 2'b00};
        mcause_q <= bus.i_trap_cause;
        mtval_q  <= bus.i_trap_val;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else if (bus.i_mret) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end
    end
  end

  assign bus.o_ready      = (state == S_IDLE);
  assign bus.o_valid      = (state == S_RESP);
  assign bus.o_rdata      = rdata_q;
  assign bus.o_illegal    = illegal_out_q;
  assign bus.o_mtvec      = mtvec_q;
  assign bus.o_mepc       = mepc_q;
  assign bus.o_mie_global = mst_mie;

endmodule
